// File: rtl/prefix_xor_seq_pkg.sv
// Shared definitions for the prefix-XOR sequencer: FSM encoding and index sizing.
package prefix_xor_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice-index width; a single-slice word still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prefix_xor_seq_prefix_xor.sv
// Narrow combinational prefix XOR: y[k] = a[0] ^ ... ^ a[k].
module prefix_xor_seq_prefix_xor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    logic acc;

    // Ripple the running parity across the slice.
    always_comb begin
        acc = 1'b0;
        y   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc  = acc ^ a[i];
            y[i] = acc;
        end
    end

endmodule

// File: rtl/prefix_xor_seq.sv
// Multi-cycle prefix XOR of a CHUNK*CHUNKS word, one slice per clock, LSB first.
module prefix_xor_seq
    import prefix_xor_seq_pkg::*;
#(
    parameter int CHUNK  = 8,
    parameter int CHUNKS = 4
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst_n,
    input  logic                    iw_in_valid,
    output logic                    ow_in_ready,
    input  logic [CHUNK*CHUNKS-1:0] iwv_in,
    output logic                    ow_out_valid,
    input  logic                    iw_out_ready,
    output logic [CHUNK*CHUNKS-1:0] owv_out,
    output logic                    ow_busy
);

    localparam int TOTAL = CHUNK * CHUNKS;
    localparam int IW    = idx_w(CHUNKS);
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    state_t state, state_nxt;

    logic [CHUNKS-1:0][CHUNK-1:0] in_reg;
    logic [CHUNKS-1:0][CHUNK-1:0] out_reg;
    logic [IW-1:0]                idx;
    logic                         carry;
    logic [CHUNK-1:0]             slice;
    logic [CHUNK-1:0]             px;
    logic [CHUNK-1:0]             res;

    // State register.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic; DONE waits for the consumer, IDLE waits for a word.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iw_in_valid)       state_nxt = RUN;
            RUN:     if (idx == LAST)       state_nxt = DONE;
            DONE:    if (iw_out_ready)      state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Select the slice currently being processed.
    always_comb begin
        slice = '0;
        for (int j = 0; j < CHUNKS; j++)
            if (idx == IW'(j)) slice = in_reg[j];
    end

    prefix_xor_seq_prefix_xor #(.WIDTH(CHUNK)) u_px (
        .a (slice),
        .y (px)
    );

    // Fold in the parity of all lower slices.
    assign res = px ^ {CHUNK{carry}};

    // Datapath: latch on accept, then fill the result one slice per cycle.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            in_reg  <= '0;
            out_reg <= '0;
            idx     <= '0;
            carry   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (iw_in_valid) begin
                    in_reg <= iwv_in;
                    idx    <= '0;
                    carry  <= 1'b0;
                end
                RUN: begin
                    for (int j = 0; j < CHUNKS; j++)
                        if (idx == IW'(j)) out_reg[j] <= res;
                    carry <= res[CHUNK-1];
                    idx   <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs come only from registers and state decode.
    assign ow_in_ready  = (state == IDLE);
    assign ow_out_valid = (state == DONE);
    assign ow_busy      = (state != IDLE);
    assign owv_out      = TOTAL'(out_reg);

endmodule
